// File: rtl/vga_timing_if.sv
// Bus between the VGA timing generator and its pixel source / display sink.
//   master : timing generator side (takes en, rgb_in; drives timing and colour)
//   slave  : user side (drives en, rgb_in; observes timing and colour)
// Signals:
//   en          run enable
//   rgb_in      pixel colour {r,g,b} for the current x,y
//   pix_en      one-clk pixel tick
//   x, y        current horizontal / vertical count
//   active      visible-area flag
//   line_start  pixel tick at x==0
//   frame_start pixel tick at x==0,y==0
//   hsync/vsync registered sync pulses
//   r, g, b     registered colour channels
interface vga_timing_if #(
  parameter int unsigned XW      = 10,
  parameter int unsigned YW      = 10,
  parameter int unsigned COLOR_W = 4
);
  logic                   en;
  logic [3*COLOR_W-1:0]   rgb_in;
  logic                   pix_en;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic                   active;
  logic                   line_start;
  logic                   frame_start;
  logic                   hsync;
  logic                   vsync;
  logic [COLOR_W-1:0]     r;
  logic [COLOR_W-1:0]     g;
  logic [COLOR_W-1:0]     b;

  modport master (
    input  en, rgb_in,
    output pix_en, x, y, active, line_start, frame_start,
           hsync, vsync, r, g, b
  );

  modport slave (
    output en, rgb_in,
    input  pix_en, x, y, active, line_start, frame_start,
           hsync, vsync, r, g, b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider, h/v raster counters, registered
// sync pulses and a one-pixel colour pipeline gated by the visible area.
// Ports:
//   clk   single system clock, all state on its rising edge
//   reset synchronous, active-high; restarts at pixel (0,0)
//   bus   vga_timing_if.master (en, rgb_in in; pix_en, x, y, active,
//         line_start, frame_start, hsync, vsync, r, g, b out)
// pix_en, x, y, active, line_start and frame_start are combinational from the
// counters; hsync, vsync, r, g, b are registered one clk after the pixel tick.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned COLOR_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  vga_timing_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = $clog2(H_TOTAL);
  localparam int unsigned YW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

  // One extra bit so sync-window bounds equal to H_TOTAL/V_TOTAL still fit.
  localparam logic [XW:0] H_ACT    = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0] HS_START = (XW+1)'(H_ACTIVE + H_FP);
  localparam logic [XW:0] HS_END   = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW:0] V_ACT    = (YW+1)'(V_ACTIVE);
  localparam logic [YW:0] VS_START = (YW+1)'(V_ACTIVE + V_FP);
  localparam logic [YW:0] VS_END   = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0]      div_q, div_d;
  logic [XW-1:0]      h_q, h_d;
  logic [YW-1:0]      v_q, v_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;

  logic pix_en_c;
  logic active_c;
  logic h_last_c;
  logic v_last_c;
  logic hs_win_c;
  logic vs_win_c;

  // Raster decode from the current counters.
  always_comb begin
    pix_en_c = bus.en && (div_q == DIV_LAST);
    h_last_c = (h_q == H_LAST);
    v_last_c = (v_q == V_LAST);
    active_c = ({1'b0, h_q} < H_ACT) && ({1'b0, v_q} < V_ACT);
    hs_win_c = ({1'b0, h_q} >= HS_START) && ({1'b0, h_q} < HS_END);
    vs_win_c = ({1'b0, v_q} >= VS_START) && ({1'b0, v_q} < VS_END);
  end

  // Next-state: everything holds unless enabled; counters and the output
  // pipeline only move on the pixel tick.
  always_comb begin
    div_d   = div_q;
    h_d     = h_q;
    v_d     = v_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;

    if (bus.en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    if (pix_en_c) begin
      h_d = h_last_c ? '0 : h_q + XW'(1);
      if (h_last_c) begin
        v_d = v_last_c ? '0 : v_q + YW'(1);
      end
      hsync_d = hs_win_c ? HS_POL : ~HS_POL;
      vsync_d = vs_win_c ? VS_POL : ~VS_POL;
      if (active_c) begin
        r_d = bus.rgb_in[3*COLOR_W-1:2*COLOR_W];
        g_d = bus.rgb_in[2*COLOR_W-1:COLOR_W];
        b_d = bus.rgb_in[COLOR_W-1:0];
      end else begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
      end
    end
  end

  // State register; reset wins over enable and restarts at pixel (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign bus.pix_en      = pix_en_c;
  assign bus.x           = h_q;
  assign bus.y           = v_q;
  assign bus.active      = active_c;
  assign bus.line_start  = pix_en_c && (h_q == '0);
  assign bus.frame_start = pix_en_c && (h_q == '0) && (v_q == '0);
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.r           = r_q;
  assign bus.g           = g_q;
  assign bus.b           = b_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)
- CLK_DIV, 2, clk cycles per pixel (>=1)
- COLOR_W, 4, bits per colour channel

REQ-002 Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).

REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single system clock; all state on its rising edge
- reset, in, 1, synchronous, active-high
- en, in, 1, run enable; low freezes all state
- rgb_in, in, 3*COLOR_W, pixel colour {r,g,b} for current x,y
- pix_en, out, 1, one-clk pixel tick
- x, out, XW, current horizontal count
- y, out, YW, current vertical count
- active, out, 1, x<H_ACTIVE and y<V_ACTIVE
- line_start, out, 1, pix_en with x==0
- frame_start, out, 1, pix_en with x==0 and y==0
- hsync, out, 1, registered horizontal sync
- vsync, out, 1, registered vertical sync
- r, out, COLOR_W, registered red channel
- g, out, COLOR_W, registered green channel
- b, out, COLOR_W, registered blue channel

Function
REQ-004 Divider SHALL count 0..CLK_DIV-1 while en=1 and wrap; pix_en=1 exactly when en=1 and divider==CLK_DIV-1; CLK_DIV=1 gives pix_en=en.
REQ-005 Horizontal counter h SHALL advance on pix_en, wrapping H_TOTAL-1 -> 0; vertical counter v SHALL advance on pix_en only when h==H_TOTAL-1, wrapping V_TOTAL-1 -> 0.
REQ-006 x, y, active, line_start and frame_start SHALL be combinational from h, v and pix_en (x=h, y=v), valid in the cycle pix_en is high.
REQ-007 rgb_in SHALL be sampled in the pix_en cycle: r,g,b <= active ? rgb_in fields : 0 (rgb_in[3C-1:2C]=r, [2C-1:C]=g, [C-1:0]=b).
REQ-008 hsync SHALL be registered on pix_en as HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL; vsync likewise using v and VS_POL.
REQ-009 hsync, vsync, r, g, b SHALL change one clk after the pix_en cycle and hold for CLK_DIV clks (one-pixel pipeline latency, mutually aligned).
REQ-010 en=0 SHALL hold divider, h, v and all registered outputs; pix_en=0 while en=0; resume continues from held state with no skipped or repeated pixel.
REQ-011 Counter arithmetic SHALL be unsigned at XW/YW bits; h/v SHALL never exceed H_TOTAL-1/V_TOTAL-1.

Reset
REQ-012 reset=1 SHALL on the next clk edge set divider=0, h=0, v=0, r=g=b=0, hsync=~HS_POL, vsync=~VS_POL; therefore x=0, y=0, active=1, pix_en=0.
REQ-013 reset SHALL take priority over en and over an in-progress line/frame (mid-frame reset restarts at pixel 0,0).
REQ-014 First pix_en after reset release (en=1) SHALL occur CLK_DIV clks later with x=0,y=0 and frame_start=1.

Verification
REQ-015 Defaults, en=1: pix_en period 2 clks; line_start period 1600 clks; frame_start period 840000 clks.
REQ-016 Defaults: hsync low for exactly 96 pixels (192 clks), falling one clk after pix_en with x=656; vsync low for lines 490-491 (2 lines, 3200 clks).
REQ-017 rgb_in=12'hF0A constant: r=F,g=0,b=A while outputs reflect x<640,y<480; r=g=b=0 for pixel x=640 and blanking lines.
REQ-018 Small params (H 4/1/1/1, V 3/1/1/1, CLK_DIV=1, HS_POL=VS_POL=1): x sequence 0..6 wraps, y wraps 0..5, hsync high for h==5 only, active-high polarity.
REQ-019 Deassert en for 7 clks mid-line at x=100: x, hsync, r/g/b frozen, pix_en=0; after en=1, next pix_en shows x=101.
REQ-020 Assert reset one clk at x=300,y=200: next clk x=0,y=0, pix_en=0, hsync=vsync=1 (defaults), r=g=b=0; frame_start 2 clks after release.
